// File: rtl/k_and_s_datapath_if.sv
// Decode type package and the control/RAM interface of the K&S datapath.
// Master = control unit and RAM side, slave = datapath.
package k_and_s_pkg;
   typedef enum logic [3:0] {
      I_NOP, I_BRANCH, I_LOAD, I_STORE, I_MOVE,
      I_ADD, I_SUB, I_AND, I_OR, I_HALT
   } decoded_instruction_type;
endpackage

interface k_and_s_datapath_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
);
   import k_and_s_pkg::*;

   logic                    branch;
   logic                    pc_enable;
   logic                    ir_enable;
   logic                    write_reg_enable;
   logic                    addr_sel;
   logic                    c_sel;
   logic [1:0]              operation;
   logic                    flags_reg_enable;
   decoded_instruction_type decoded_instruction;
   logic                    zero_op;
   logic                    neg_op;
   logic                    unsigned_overflow;
   logic                    signed_overflow;
   logic [ADDR_W-1:0]       ram_addr;
   logic [DATA_W-1:0]       data_out;
   logic [DATA_W-1:0]       data_in;

   modport master (
      output branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
             c_sel, operation, flags_reg_enable, data_in,
      input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
             signed_overflow, ram_addr, data_out
   );

   modport slave (
      input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
             c_sel, operation, flags_reg_enable, data_in,
      output decoded_instruction, zero_op, neg_op, unsigned_overflow,
             signed_overflow, ram_addr, data_out
   );
endinterface

// File: rtl/k_and_s_datapath.sv
// K&S datapath: PC, IR, 4x16 register file, ALU, flags and IR decode.
// Optional K_AND_S_DATAPATH_R0_ZERO_EN hardwires R0 to zero.
module k_and_s_datapath
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int NREG   = 4
) (
   input logic              clk,
   input logic              rst,
   k_and_s_datapath_if.slave bus
);
   localparam int MSB = DATA_W - 1;

   logic [ADDR_W-1:0]       pc_q, pc_d;
   logic [DATA_W-1:0]       ir_q, ir_d;
   logic [DATA_W-1:0]       regs_q [NREG];
   logic [3:0]              flags_q, flags_d;

   decoded_instruction_type dec;
   logic [1:0]              a_sel, b_sel, st_sel, wr_sel;
   logic [DATA_W-1:0]       rd_a, rd_b, rd_st, alu_b, res, wr_data;
   logic [DATA_W:0]         sum;
   logic                    uov, sov, wr_en;
   logic                    unused_ir7;

   assign unused_ir7 = ir_q[7];

   always_comb begin
      case (ir_q[15:8])
         8'h01:   dec = I_BRANCH;
         8'h81:   dec = I_LOAD;
         8'h82:   dec = I_STORE;
         8'h91:   dec = I_MOVE;
         8'hA1:   dec = I_ADD;
         8'hA2:   dec = I_SUB;
         8'hA3:   dec = I_AND;
         8'hA4:   dec = I_OR;
         8'hFF:   dec = I_HALT;
         default: dec = I_NOP;
      endcase
   end

   assign a_sel  = ir_q[3:2];
   assign b_sel  = ir_q[5:4];
   assign st_sel = ir_q[6:5];
   assign wr_sel = (dec == I_LOAD) ? ir_q[6:5] : ir_q[1:0];

`ifdef K_AND_S_DATAPATH_R0_ZERO_EN
   assign rd_a  = (a_sel  == 2'd0) ? '0 : regs_q[a_sel];
   assign rd_b  = (b_sel  == 2'd0) ? '0 : regs_q[b_sel];
   assign rd_st = (st_sel == 2'd0) ? '0 : regs_q[st_sel];
   assign wr_en = bus.write_reg_enable && (wr_sel != 2'd0);
`else
   assign rd_a  = regs_q[a_sel];
   assign rd_b  = regs_q[b_sel];
   assign rd_st = regs_q[st_sel];
   assign wr_en = bus.write_reg_enable;
`endif

   // MOVE forces B to zero so that OR passes A through unchanged
   assign alu_b = (dec == I_MOVE) ? '0 : rd_b;

   always_comb begin
      sum = '0;
      res = '0;
      uov = 1'b0;
      sov = 1'b0;
      case (bus.operation)
         2'b00: begin
            sum = {1'b0, rd_a} + {1'b0, alu_b};
            res = sum[MSB:0];
            uov = sum[DATA_W];
            sov = (rd_a[MSB] == alu_b[MSB]) && (res[MSB] != rd_a[MSB]);
         end
         2'b01: begin
            // A + ~B + 1: carry out clear means a borrow occurred
            sum = {1'b0, rd_a} + {1'b0, ~alu_b} + {{DATA_W{1'b0}}, 1'b1};
            res = sum[MSB:0];
            uov = ~sum[DATA_W];
            sov = (rd_a[MSB] != alu_b[MSB]) && (res[MSB] != rd_a[MSB]);
         end
         2'b10:   res = rd_a & alu_b;
         default: res = rd_a | alu_b;
      endcase
   end

   assign wr_data = bus.c_sel ? bus.data_in : res;
   assign pc_d    = bus.branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
   assign ir_d    = bus.data_in;
   assign flags_d = {(res == '0), res[MSB], uov, sov};

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         ir_q    <= '0;
         flags_q <= '0;
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         if (bus.pc_enable)        pc_q           <= pc_d;
         if (bus.ir_enable)        ir_q           <= ir_d;
         if (bus.flags_reg_enable) flags_q        <= flags_d;
         if (wr_en)                regs_q[wr_sel] <= wr_data;
      end
   end

   assign bus.decoded_instruction = dec;
   assign bus.ram_addr            = bus.addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
   assign bus.data_out            = rd_st;
   assign bus.zero_op             = flags_q[3];
   assign bus.neg_op              = flags_q[2];
   assign bus.unsigned_overflow   = flags_q[1];
   assign bus.signed_overflow     = flags_q[0];
endmodule

// File: tb/tb_k_and_s_datapath.sv
// Scoreboard bench for k_and_s_datapath: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_k_and_s_datapath;
   import k_and_s_pkg::*;

   localparam int SEL_ADDR = 0, SEL_DEC = 1, SEL_DOUT = 2, SEL_FLAGS = 3;

   typedef struct {
      string       name;
      int          sel;
      logic [15:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   k_and_s_datapath_if #(.DATA_W(16), .ADDR_W(5)) bus ();

   k_and_s_datapath #(.DATA_W(16), .ADDR_W(5), .NREG(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [15:0] act;
         e = q.pop_front();
         case (e.sel)
            SEL_ADDR: act = {11'd0, bus.ram_addr};
            SEL_DEC:  act = {12'd0, bus.decoded_instruction};
            SEL_DOUT: act = bus.data_out;
            default:  act = {12'd0, bus.zero_op, bus.neg_op,
                             bus.unsigned_overflow, bus.signed_overflow};
         endcase
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic expect_v(input string name, input int sel, input logic [15:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.branch           = 1'b0;
      bus.pc_enable        = 1'b0;
      bus.ir_enable        = 1'b0;
      bus.write_reg_enable = 1'b0;
      bus.addr_sel         = 1'b0;
      bus.c_sel            = 1'b0;
      bus.operation        = 2'b00;
      bus.flags_reg_enable = 1'b0;
   endtask

   task automatic load_ir(input logic [15:0] w);
      idle();
      bus.data_in   = w;
      bus.ir_enable = 1'b1;
      step();
      idle();
   endtask

   task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
      load_ir({8'h81, 1'b0, r, 5'd0});
      bus.data_in          = v;
      bus.c_sel            = 1'b1;
      bus.write_reg_enable = 1'b1;
      step();
      idle();
   endtask

   task automatic check_reg(input string name, input logic [1:0] r, input logic [15:0] v);
      load_ir({8'h82, 1'b0, r, 5'd0});
      expect_v(name, SEL_DOUT, v);
      step();
   endtask

   task automatic alu_op(input logic [15:0] ir, input logic [1:0] op, input logic fl);
      load_ir(ir);
      bus.operation        = op;
      bus.write_reg_enable = 1'b1;
      bus.flags_reg_enable = fl;
      step();
      idle();
   endtask

   initial begin
      logic [7:0] ops  [12];
      logic [3:0] decs [12];
      ops  = '{8'h00, 8'h01, 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'h55, 8'h80};
      decs = '{I_NOP, I_BRANCH, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT, I_NOP, I_NOP};

      idle();
      bus.data_in = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      expect_v("reset_pc", SEL_ADDR, 16'd0);
      expect_v("reset_dec", SEL_DEC, 16'(I_NOP));
      expect_v("reset_flags", SEL_FLAGS, 16'h0);
      expect_v("reset_dout", SEL_DOUT, 16'h0);
      step();
      bus.addr_sel = 1'b1;
      expect_v("reset_ir_addr", SEL_ADDR, 16'd0);
      step();

      // fetch
      idle();
      bus.data_in   = 16'hA124;
      bus.ir_enable = 1'b1;
      bus.pc_enable = 1'b1;
      step();
      idle();
      expect_v("fetch_pc", SEL_ADDR, 16'd1);
      expect_v("fetch_dec", SEL_DEC, 16'(I_ADD));
      step();
      bus.addr_sel = 1'b1;
      expect_v("fetch_ir_addr", SEL_ADDR, 16'h04);
      step();

      // PC wrap 31 -> 0
      idle();
      bus.pc_enable = 1'b1;
      repeat (30) step();
      idle();
      expect_v("pc_31", SEL_ADDR, 16'd31);
      step();
      bus.pc_enable = 1'b1;
      step();
      idle();
      expect_v("pc_wrap", SEL_ADDR, 16'd0);
      step();

      // decode table
      for (int i = 0; i < 12; i++) begin
         load_ir({ops[i], 8'h00});
         expect_v($sformatf("decode_%h", ops[i]), SEL_DEC, {12'd0, decs[i]});
         step();
      end

      // LOAD
      load_ir(16'h8125);
      bus.addr_sel = 1'b1;
      expect_v("load_addr", SEL_ADDR, 16'd5);
      step();
      bus.data_in          = 16'h7FFF;
      bus.c_sel            = 1'b1;
      bus.write_reg_enable = 1'b1;
      step();
      idle();
      check_reg("load_r1", 2'd1, 16'h7FFF);

      // ADD signed overflow
      write_reg(2'd2, 16'h0001);
      alu_op(16'hA124, 2'b00, 1'b1);
      expect_v("add_flags", SEL_FLAGS, 16'b1010 >> 1);
`ifdef K_AND_S_DATAPATH_R0_ZERO_EN
      check_reg("add_r0", 2'd0, 16'h0000);
`else
      check_reg("add_r0", 2'd0, 16'h8000);
`endif

      // SUB equal
      write_reg(2'd1, 16'h1234);
      write_reg(2'd2, 16'h1234);
      alu_op(16'hA227, 2'b01, 1'b1);
      expect_v("sub_eq_flags", SEL_FLAGS, 16'b1000);
      check_reg("sub_eq_r3", 2'd3, 16'h0000);

      // SUB borrow
      write_reg(2'd1, 16'h0001);
      write_reg(2'd2, 16'h0002);
      alu_op(16'hA227, 2'b01, 1'b1);
      expect_v("sub_borrow_flags", SEL_FLAGS, 16'b0110);
      check_reg("sub_borrow_r3", 2'd3, 16'hFFFF);

      // AND / OR
      write_reg(2'd1, 16'h0F0F);
      write_reg(2'd2, 16'hF0F0);
      alu_op(16'hA327, 2'b10, 1'b1);
      expect_v("and_flags", SEL_FLAGS, 16'b1000);
      check_reg("and_r3", 2'd3, 16'h0000);
      alu_op(16'hA427, 2'b11, 1'b1);
      expect_v("or_flags", SEL_FLAGS, 16'b0100);
      check_reg("or_r3", 2'd3, 16'hFFFF);

      // ADD unsigned carry
      write_reg(2'd1, 16'hFFFF);
      write_reg(2'd2, 16'h0001);
      alu_op(16'hA127, 2'b00, 1'b1);
      expect_v("add_carry_flags", SEL_FLAGS, 16'b1010);
      check_reg("add_carry_r3", 2'd3, 16'h0000);

      // MOVE, flags not strobed so they hold
      write_reg(2'd1, 16'h5A5A);
      write_reg(2'd2, 16'hFFFF);
      load_ir(16'h9127);
      expect_v("move_dec", SEL_DEC, 16'(I_MOVE));
      bus.operation        = 2'b11;
      bus.write_reg_enable = 1'b1;
      step();
      idle();
      expect_v("flags_hold", SEL_FLAGS, 16'b1010);
      check_reg("move_r3", 2'd3, 16'h5A5A);

      // BRANCH
      load_ir(16'h0113);
      expect_v("branch_dec", SEL_DEC, 16'(I_BRANCH));
      bus.branch    = 1'b1;
      bus.pc_enable = 1'b1;
      step();
      idle();
      expect_v("branch_pc", SEL_ADDR, 16'h13);
      step();

      // read during write returns old value
      load_ir(16'h8120);
      bus.data_in          = 16'h1111;
      bus.c_sel            = 1'b1;
      bus.write_reg_enable = 1'b1;
      expect_v("rdw_old", SEL_DOUT, 16'h5A5A);
      step();
      idle();
      expect_v("rdw_new", SEL_DOUT, 16'h1111);
      step();

      // reset mid-LOAD
      bus.data_in          = 16'hBEEF;
      bus.c_sel            = 1'b1;
      bus.write_reg_enable = 1'b1;
      bus.flags_reg_enable = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      expect_v("rst_mid_pc", SEL_ADDR, 16'd0);
      expect_v("rst_mid_flags", SEL_FLAGS, 16'h0);
      expect_v("rst_mid_dec", SEL_DEC, 16'(I_NOP));
      step();
      bus.addr_sel = 1'b1;
      expect_v("rst_mid_ir", SEL_ADDR, 16'd0);
      step();
      check_reg("rst_mid_r1", 2'd1, 16'h0000);
      check_reg("rst_mid_r3", 2'd3, 16'h0000);

      idle();
      step();
      step();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
